// File: rtl/mod_if_arbiter.sv
// ---------------------------------------------------------------------------
// mod_if_arbiter
//   Round-robin arbiter sharing one mod_if slave port between N masters.
//   Exactly one master owns the bus at a time. Its c/d outputs are muxed onto
//   the slave side. An owner that holds the bus for MAX_HOLD cycles while
//   someone else is waiting is preempted. Every tenure ends with one
//   undriven TURN cycle.
//
// Ports
//   clk      in   1        rising-edge clock
//   rst_n    in   1        asynchronous active-low reset
//   req      in   N        per-master level request
//   m_c      in   N*DW     masters' c outputs, master i at [i*DW +: DW]
//   m_d      in   N*DW     masters' d outputs, same packing
//   grant    out  N        one-hot grant, zero when the bus is unowned
//   owner    out  $clog2(N) index of current owner, 0 when not busy
//   busy     out  1        |grant
//   preempt  out  1        one-cycle pulse in the TURN cycle after a timeout
//   s_c      out  DW       owner's c slice, zero when not busy
//   s_d      out  DW       owner's d slice, zero when not busy
// ---------------------------------------------------------------------------

// Per-master slice gate: passes one master's c/d only while it owns the bus.
module mod_if_arbiter_lane #(
   parameter int OW  = 2,
   parameter int DW  = 1,
   parameter int IDX = 0
) (
   input  logic          busy,
   input  logic [OW-1:0] owner,
   input  logic [DW-1:0] c_in,
   input  logic [DW-1:0] d_in,
   output logic [DW-1:0] c_out,
   output logic [DW-1:0] d_out
);
   localparam logic [OW-1:0] MY_IDX = OW'(IDX);

   logic sel;

   assign sel   = busy && (owner == MY_IDX);
   assign c_out = sel ? c_in : '0;
   assign d_out = sel ? d_in : '0;
endmodule

module mod_if_arbiter #(
   parameter int N        = 4,
   parameter int DW       = 1,
   parameter int MAX_HOLD = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic [N*DW-1:0]      m_c,
   input  logic [N*DW-1:0]      m_d,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] owner,
   output logic                 busy,
   output logic                 preempt,
   output logic [DW-1:0]        s_c,
   output logic [DW-1:0]        s_d
);
   localparam int OW = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);
   localparam logic [OW-1:0] LAST_RST = OW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      TURN = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [OW-1:0] last_q, last_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic          preempt_q, preempt_d;
   logic [N-1:0]  req_q, req_d;

   // -------------------------------------------------------------------------
   // Request qualification. A master is eligible in IDLE only when its req is
   // high both at the arbitration edge and at the edge before it. This gives
   // the one-cycle evaluation delay for a fresh request and ignores short
   // req blips that happen while the bus is busy or turning around.
   // -------------------------------------------------------------------------
   logic [N-1:0] elig;

   assign req_d = req;
   assign elig  = req & req_q;

   // -------------------------------------------------------------------------
   // Round-robin pick. Distance 0 is the master right after last_q. The
   // smallest distance among eligible masters wins. i + N - 1 - last stays
   // non-negative because last_q <= N-1.
   // -------------------------------------------------------------------------
   logic          win_vld;
   logic [OW-1:0] win_idx;
   int            best;

   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      best    = N;
      for (int i = 0; i < N; i++) begin
         if (elig[i] && (((i + N - 1 - int'(last_q)) % N) < best)) begin
            best    = (i + N - 1 - int'(last_q)) % N;
            win_idx = OW'(i);
            win_vld = 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Owner status.
   // -------------------------------------------------------------------------
   logic own_req;
   logic others_req;

   assign own_req    = |(req & grant_q);
   assign others_req = |(req & ~grant_q);

   // -------------------------------------------------------------------------
   // Next-state logic.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      owner_d    = owner_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      preempt_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (win_vld) begin
               grant_d    = {{(N-1){1'b0}}, 1'b1} << win_idx;
               owner_d    = win_idx;
               hold_cnt_d = '0;
               state_d    = OWN;
            end
         end

         OWN: begin
            // Release wins over timeout: dropping req on the timeout edge
            // is a normal release without a preempt pulse.
            if (!own_req) begin
               grant_d = '0;
               last_d  = owner_q;
               owner_d = '0;
               state_d = TURN;
            end else if ((hold_cnt_q == HOLD_MAX) && others_req) begin
               grant_d   = '0;
               last_d    = owner_q;
               owner_d   = '0;
               preempt_d = 1'b1;
               state_d   = TURN;
            end else if (hold_cnt_q != HOLD_MAX) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end

         TURN: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            grant_d = '0;
            owner_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         owner_q    <= '0;
         last_q     <= LAST_RST;
         hold_cnt_q <= '0;
         preempt_q  <= 1'b0;
         req_q      <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         preempt_q  <= preempt_d;
         req_q      <= req_d;
      end
   end

   assign grant   = grant_q;
   assign owner   = owner_q;
   assign busy    = |grant_q;
   assign preempt = preempt_q;

   // -------------------------------------------------------------------------
   // Datapath. This is combinational from registered owner/busy and live
   // master outputs. An async reset clears busy, so s_c/s_d go to zero at
   // once.
   // -------------------------------------------------------------------------
   logic [N-1:0][DW-1:0] lane_c;
   logic [N-1:0][DW-1:0] lane_d;

   for (genvar i = 0; i < N; i++) begin : g_lane
      mod_if_arbiter_lane #(
         .OW  (OW),
         .DW  (DW),
         .IDX (i)
      ) u_lane (
         .busy  (busy),
         .owner (owner_q),
         .c_in  (m_c[i*DW +: DW]),
         .d_in  (m_d[i*DW +: DW]),
         .c_out (lane_c[i]),
         .d_out (lane_d[i])
      );
   end

   // At most one lane is non-zero, so OR-ing the lanes acts as the mux.
   always_comb begin
      s_c = '0;
      s_d = '0;
      for (int i = 0; i < N; i++) begin
         s_c = s_c | lane_c[i];
         s_d = s_d | lane_d[i];
      end
   end
endmodule

// File: doc/mod_if_arbiter.md
# mod_if_arbiter

Round-robin arbiter that shares one `mod_if` slave port between `N` bus masters. Each master presents `req` plus its `c`/`d` outputs. The arbiter grants exactly one master at a time and muxes that master's `c`/`d` onto the slave side. It sits between the master instances and the single `mod_if.slave` instance in the testbench/top. The slave's `a`/`b` outputs are broadcast unchanged to all masters outside this block.

## Interface
Parameters:
- `N`, default 4: number of masters; legal range 2..8.
- `DW`, default 1: width of the `c` and `d` signals.
- `MAX_HOLD`, default 8: maximum number of cycles an owner keeps the bus while others wait; legal range ≥2.

Ports:
- `clk`, input, 1: single clock; all state on the rising edge.
- `rst_n`, input, 1: reset is asynchronous and active-low.
- `req`, input, N: per-master bus request; level-sensitive.
- `m_c`, input, N*DW: masters' `c` outputs; master i occupies bits [i*DW +: DW].
- `m_d`, input, N*DW: masters' `d` outputs, same packing as `m_c`.
- `grant`, output, N: one-hot grant; all zeros when the bus is unowned.
- `owner`, output, $clog2(N): index of the current owner; 0 when `busy`=0.
- `busy`, output, 1: high while any grant is asserted.
- `preempt`, output, 1: one-cycle pulse when an owner loses the bus by timeout.
- `s_c`, output, DW: drives the slave `c` input.
- `s_d`, output, DW: drives the slave `d` input.

## Operation
- State machine states: IDLE, OWN, TURN.
- IDLE
  - If `req`≠0, pick the winner by round-robin: search starts at `last`+1 mod N and wraps.
  - Load a one-hot `grant` for the winner, set `owner`, clear `hold_cnt`, go to OWN.
  - If `req`=0, stay in IDLE.
- OWN
  - Each cycle, `hold_cnt` increments and saturates at MAX_HOLD-1.
  - Normal release: owner's `req` is low at the clock edge. Clear `grant`, set `last`=owner, go to TURN.
  - Preempt: owner's `req` is high, `hold_cnt`==MAX_HOLD-1, and any other `req` bit is high. Clear `grant`, set `last`=owner, pulse `preempt`, go to TURN.
  - If `hold_cnt` saturates with no other requester, ownership continues indefinitely; no preempt.
- TURN
  - Exactly one cycle with the bus undriven: `grant`=0 and `s_c`/`s_d`=0.
  - Then go unconditionally to IDLE.
- Datapath
  - `s_c` = slice of `m_c` selected by `owner` when `busy`=1; otherwise all zeros. Same rule for `s_d`.
  - The datapath is purely combinational from registered `owner`/`busy` and live `m_c`/`m_d`.
- Round-robin pointer `last`
  - Resets to N-1, so master 0 has first priority after reset.
  - Wrap: after owner N-1, the search starts at 0.
- Arbitration uses only the `req` values sampled at the IDLE-cycle edge. A `req` pulse that rises and falls within OWN/TURN is never seen.
- A preempted master that still holds `req` high re-enters arbitration with lowest priority, because it is now `last`.
- Reset, asynchronous and allowed at any point including mid-OWN:
  - State=IDLE; `grant`, `busy`, `preempt`, `hold_cnt` = 0; `owner`=0; `last`=N-1.
  - `s_c`/`s_d`=0 immediately.

## Timing
- Request-to-grant latency:
  - `req` high before edge E while in IDLE gives `grant` high after edge E+1.
  - The IDLE cycle containing E evaluates the request, so the grant takes effect one cycle later.
- Release-to-regrant:
  - Owner drops `req` before edge R: `grant` is low after R (TURN), state is IDLE after R+1.
  - Next `grant` after R+2 at the earliest. Minimum bus gap is 2 cycles with `grant`=0.
- Maximum tenure under contention:
  - MAX_HOLD cycles with `grant` high, counting the first OWN cycle as `hold_cnt`=0.
  - `preempt` is high in the first TURN cycle only.
- Simultaneous events:
  - Owner drops `req` on the same edge its timeout fires: treat as a normal release, `preempt`=0.
  - Multiple new requests in IDLE: round-robin decides; there is no fixed priority.
- Invariants:
  - `grant` is never multi-hot.
  - `busy` == |`grant`.
  - `owner` is consistent with `grant` in every cycle.

## Test plan
All scenarios use N=4, DW=1, MAX_HOLD=8.
- Reset mid-OWN: assert `rst_n`=0 while master 1 owns the bus -> `grant`=0, `s_c`=0 asynchronously. After release, `req`=4'b0011 -> master 0 granted first.
- Single master: `req`=4'b0100 with `m_c[2]`=1 -> `grant`=4'b0100 two edges later and `s_c`=1. Drop `req` -> `grant`=0 for exactly 2 cycles; `preempt` stays 0.
- Round-robin fairness: `req`=4'b1111, each owner holds for 3 cycles -> grant order is 0,1,2,3,0; 5 cycles from one grant to the next; no preempt.
- Timeout preempt: master 0 holds `req` forever and master 3 requests -> master 0 gets exactly 8 grant cycles, `preempt` pulses once, master 3 is granted 2 cycles later.
- No-contention saturation: master 2 alone holds `req` for 50 cycles -> `grant` stays high for all 50 cycles; `preempt` never asserts.
- Release/timeout collision: the owner drops `req` on the same edge as the MAX_HOLD boundary while another request is pending -> `preempt`=0; the next master is granted after the normal 2-cycle gap.
